matmul_mac_engine: RTL and testbench



---
 rtl/matmul_pkg.sv | 25 ++
 rtl/mac_unit.sv | 18 +
 rtl/matmul_mac_engine.sv | 144 ++++++++++++++
 tb/tb_matmul_mac_engine.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and sizes for the 2x4 by 4x2 matrix MAC engine
package matmul_pkg;

  localparam int DW    = 32;
  localparam int ROWS  = 2;
  localparam int INNER = 4;
  localparam int COLS  = 2;

  // Index widths never collapse to zero bits, so single-row/column builds still elaborate.
  localparam int IW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int JW = (COLS  > 1) ? $clog2(COLS)  : 1;

  typedef logic [DW-1:0]                        elem_t;
  typedef logic [ROWS-1:0][INNER-1:0][DW-1:0]   mat1_t;
  typedef logic [INNER-1:0][COLS-1:0][DW-1:0]   mat2_t;
  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0]    res_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } matmul_state_e;

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - combinational multiply-accumulate, product truncated to DW bits
module mac_unit
  import matmul_pkg::*;
(
  input  elem_t a_i,
  input  elem_t b_i,
  input  elem_t acc_i,
  input  logic  clr_i,
  output elem_t acc_o
);

  elem_t prod;

  // Only the low DW bits of the product are kept; modulo 2^DW is sign-agnostic.
  assign prod  = a_i * b_i;
  assign acc_o = (clr_i ? '0 : acc_i) + prod;

endmodule

// File: rtl/matmul_mac_engine.sv
// rtl/matmul_mac_engine.sv - sequential 2x4 * 4x2 matrix multiply over one shared MAC
module matmul_mac_engine
  import matmul_pkg::*;
(
  input  logic  clk_gen,
  input  logic  srst,
  input  logic  start_i,
  input  mat1_t mat1_i,
  input  mat2_t mat2_i,
  output res_t  res_o,
  output logic  busy_o,
  output logic  done_o,
  output logic  valid_o
);

  matmul_state_e state_q, state_d;
  logic          start_q;
  mat1_t         op_a_q, op_a_d;
  mat2_t         op_b_q, op_b_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  elem_t         acc_q, acc_d;
  res_t          shadow_q, shadow_d;
  res_t          res_q, res_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;

  logic          trigger;
  elem_t         acc_next;

  assign trigger = start_i & ~start_q;

  mac_unit u_mac (
    .a_i   (op_a_q[i_q][k_q]),
    .b_i   (op_b_q[k_q][j_q]),
    .acc_i (acc_q),
    .clr_i (k_q == '0),
    .acc_o (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          op_a_d  = mat1_i;
          op_b_d  = mat2_i;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end

      MAC: begin
        if (k_q == KW'(INNER-1)) begin
          // Dot product complete: park it in the shadow so res_o updates all at once later.
          shadow_d[i_q][j_q] = acc_next;
          acc_d = '0;
          k_d   = '0;
          if (j_q == JW'(COLS-1)) begin
            j_d = '0;
            if (i_q == IW'(ROWS-1)) begin
              i_d     = '0;
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d   = k_q + 1'b1;
          acc_d = acc_next;
        end
      end

      DONE: begin
        res_d   = shadow_q;
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_gen) begin
    if (srst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_i;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  assign res_o   = res_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_matmul_mac_engine.sv
// tb/tb_matmul_mac_engine.sv - self-checking bench for matmul_mac_engine
module tb_matmul_mac_engine;
  import matmul_pkg::*;

  logic  clk_gen = 1'b0;
  logic  srst;
  logic  start_i;
  mat1_t mat1_i;
  mat2_t mat2_i;
  res_t  res_o;
  logic  busy_o, done_o, valid_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_gen = ~clk_gen;

  matmul_mac_engine dut (
    .clk_gen (clk_gen),
    .srst    (srst),
    .start_i (start_i),
    .mat1_i  (mat1_i),
    .mat2_i  (mat2_i),
    .res_o   (res_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .valid_o (valid_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain matrix product, every sum wrapped to 32 bits.
  function automatic res_t model(input mat1_t a, input mat2_t b);
    res_t  r;
    elem_t s;
    for (int row = 0; row < ROWS; row++)
      for (int col = 0; col < COLS; col++) begin
        s = '0;
        for (int kk = 0; kk < INNER; kk++) s = s + a[row][kk] * b[kk][col];
        r[row][col] = s;
      end
    return r;
  endfunction

  task automatic step();
    @(posedge clk_gen);
    @(negedge clk_gen);
  endtask

  // mode 0: plain, 1: operand change + re-edge while busy, 2: srst at T+9
  task automatic run(input int mode, input res_t old_res,
                     output int busy_cnt, output int done_cnt, output int done_lat,
                     output bit res_held, output bit valid_low);
    busy_cnt = 0; done_cnt = 0; done_lat = -1; res_held = 1; valid_low = 1;
    start_i = 1'b1;
    for (int n = 0; n < 26; n++) begin
      step();
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_lat < 0) done_lat = n;
      end
      if (done_lat < 0) begin
        if (res_o !== old_res) res_held = 0;
        if (valid_o !== 1'b0) valid_low = 0;
      end
      if (mode == 1 && n == 4) mat1_i = '0;
      if (mode == 1 && n == 7) start_i = 1'b0;
      if (mode == 1 && n == 8) start_i = 1'b1;
      if (mode == 2 && n == 8) srst = 1'b1;
      if (mode == 2 && n == 9) begin
        chk("rst_mid_res", res_o, '0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_valid", valid_o, 0);
        chk("rst_mid_done", done_o, 0);
        srst = 1'b0;
        start_i = 1'b0;
      end
    end
  endtask

  res_t  exp_r, prev;
  mat1_t orig_a;
  int    bc, dc, dl;
  bit    held, vlow;

  initial begin
    srst = 1'b1; start_i = 1'b0; mat1_i = '0; mat2_i = '0;
    repeat (3) step();
    srst = 1'b0;
    step();
    chk("reset_res", res_o, '0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_valid", valid_o, 0);

    // Basic run with start held high afterwards
    mat1_i[0][0] = 1; mat1_i[0][1] = 2; mat1_i[0][2] = 3; mat1_i[0][3] = 4;
    mat1_i[1][0] = 5; mat1_i[1][1] = 6; mat1_i[1][2] = 7; mat1_i[1][3] = 8;
    mat2_i = '0;
    mat2_i[0][0] = 1; mat2_i[1][1] = 1; mat2_i[2][0] = 1; mat2_i[3][1] = 1;
    exp_r[0][0] = 4; exp_r[0][1] = 6; exp_r[1][0] = 12; exp_r[1][1] = 14;
    run(0, res_o, bc, dc, dl, held, vlow);
    chk("basic_res", res_o, exp_r);
    chk("basic_model", res_o, model(mat1_i, mat2_i));
    chk("basic_done_cnt", dc, 1);
    chk("basic_done_lat", dl, 17);
    chk("basic_busy_cnt", bc, 16);
    chk("basic_valid", valid_o, 1);
    chk("basic_busy_end", busy_o, 0);
    start_i = 1'b0;
    step();

    // Wrap-around cases
    mat1_i = '1; mat2_i = '1;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_r[r][c] = 32'h4;
    run(0, res_o, bc, dc, dl, held, vlow);
    chk("wrap_ones", res_o, exp_r);
    start_i = 1'b0; step();
    for (int r = 0; r < ROWS; r++) for (int kk = 0; kk < INNER; kk++) mat1_i[r][kk] = 32'h8000_0000;
    for (int kk = 0; kk < INNER; kk++) for (int c = 0; c < COLS; c++) mat2_i[kk][c] = 32'h2;
    run(0, res_o, bc, dc, dl, held, vlow);
    chk("wrap_zero", res_o, '0);
    start_i = 1'b0; step();

    // Random operands against the reference model
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < ROWS; r++) for (int kk = 0; kk < INNER; kk++) mat1_i[r][kk] = $urandom;
      for (int kk = 0; kk < INNER; kk++) for (int c = 0; c < COLS; c++) mat2_i[kk][c] = $urandom;
      exp_r = model(mat1_i, mat2_i);
      run(0, res_o, bc, dc, dl, held, vlow);
      chk($sformatf("rand%0d_res", t), res_o, exp_r);
      chk($sformatf("rand%0d_lat", t), dl, 17);
      start_i = 1'b0; step();
    end

    // Operand change and re-edge while busy
    for (int r = 0; r < ROWS; r++) for (int kk = 0; kk < INNER; kk++) mat1_i[r][kk] = $urandom;
    for (int kk = 0; kk < INNER; kk++) for (int c = 0; c < COLS; c++) mat2_i[kk][c] = $urandom;
    orig_a = mat1_i;
    exp_r = model(orig_a, mat2_i);
    run(1, res_o, bc, dc, dl, held, vlow);
    chk("busyedge_res", res_o, exp_r);
    chk("busyedge_done_cnt", dc, 1);
    chk("busyedge_busy_cnt", bc, 16);
    chk("busyedge_busy_end", busy_o, 0);
    start_i = 1'b0; step();

    // Reset mid-run, then a fresh run
    run(2, res_o, bc, dc, dl, held, vlow);
    chk("rst_done_cnt", dc, 0);
    chk("rst_res_after", res_o, '0);
    chk("rst_valid_after", valid_o, 0);
    mat1_i = orig_a;
    run(0, res_o, bc, dc, dl, held, vlow);
    chk("rst_fresh_res", res_o, exp_r);
    chk("rst_fresh_valid", valid_o, 1);

    // Back-to-back: one idle cycle of start, new operands
    start_i = 1'b0;
    step();
    mat1_i = '0; mat1_i[0][0] = 1; mat1_i[1][1] = 1;
    mat2_i[0][0] = 9; mat2_i[0][1] = 8; mat2_i[1][0] = 7; mat2_i[1][1] = 6;
    mat2_i[2][0] = 5; mat2_i[2][1] = 4; mat2_i[3][0] = 3; mat2_i[3][1] = 2;
    prev = res_o;
    exp_r[0][0] = 9; exp_r[0][1] = 8; exp_r[1][0] = 7; exp_r[1][1] = 6;
    run(0, prev, bc, dc, dl, held, vlow);
    chk("b2b_res_held", held, 1);
    chk("b2b_valid_low", vlow, 1);
    chk("b2b_res", res_o, exp_r);
    chk("b2b_done_cnt", dc, 1);
    chk("b2b_done_lat", dl, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
